// File: rtl/exp_seq_ctrl_pkg.sv
// Shared constants for the expansion-term sequencer: BCD digit codes,
// FSM state encoding and small BCD digit helpers.
package exp_seq_ctrl_pkg;

  localparam logic [3:0] BCD_0     = 4'h0;
  localparam logic [3:0] BCD_1     = 4'h1;
  localparam logic [3:0] BCD_2     = 4'h2;
  localparam logic [3:0] BCD_3     = 4'h3;
  localparam logic [3:0] BCD_4     = 4'h4;
  localparam logic [3:0] BCD_5     = 4'h5;
  localparam logic [3:0] BCD_6     = 4'h6;
  localparam logic [3:0] BCD_7     = 4'h7;
  localparam logic [3:0] BCD_8     = 4'h8;
  localparam logic [3:0] BCD_9     = 4'h9;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [7:0] BCD_SAT   = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Out-of-range digit codes are treated as the largest legal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_9) ? BCD_9 : d;
  endfunction

  // Digit successor; 9 has no successor within one digit and yields blank.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    logic [3:0] n;
    case (d)
      BCD_0:   n = BCD_1;
      BCD_1:   n = BCD_2;
      BCD_2:   n = BCD_3;
      BCD_3:   n = BCD_4;
      BCD_4:   n = BCD_5;
      BCD_5:   n = BCD_6;
      BCD_6:   n = BCD_7;
      BCD_7:   n = BCD_8;
      BCD_8:   n = BCD_9;
      default: n = BCD_BLANK;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/exp_seq_ctrl_if.sv
// Control/data bundle between the sequencer and its environment
// (buttons, term table, display mux).
interface exp_seq_ctrl_if;
  logic       start_btn;
  logic       step_btn;
  logic       auto_en;
  logic [7:0] term_bcd;
  logic       run;
  logic [3:0] cur_exp;
  logic [7:0] sum_val;
  logic       load;
  logic       ovf;
  logic       done;

  modport master (
    output start_btn, step_btn, auto_en, term_bcd,
    input  run, cur_exp, sum_val, load, ovf, done
  );

  modport slave (
    input  start_btn, step_btn, auto_en, term_bcd,
    output run, cur_exp, sum_val, load, ovf, done
  );
endinterface

// File: rtl/exp_seq_ctrl_bcd_add8.sv
// Combinational 2-digit BCD adder; each input digit is clamped to 9 first.
// result = {carry_out_of_tens, tens, ones}.
module bcd_add8
  import exp_seq_ctrl_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] result
);

  logic [4:0] ones_raw_s;
  logic [4:0] tens_raw_s;
  logic [3:0] ones_s;
  logic [3:0] tens_s;
  logic       ones_c_s;
  logic       tens_c_s;

  // Digit-serial add with +6 decimal correction on each digit
  always_comb begin
    ones_raw_s = {1'b0, bcd_clamp(a[3:0])} + {1'b0, bcd_clamp(b[3:0])};
    if (ones_raw_s > 5'd9) begin
      ones_c_s = 1'b1;
      ones_s   = 4'(ones_raw_s + 5'd6);
    end else begin
      ones_c_s = 1'b0;
      ones_s   = ones_raw_s[3:0];
    end
    tens_raw_s = {1'b0, bcd_clamp(a[7:4])} + {1'b0, bcd_clamp(b[7:4])} + {4'd0, ones_c_s};
    if (tens_raw_s > 5'd9) begin
      tens_c_s = 1'b1;
      tens_s   = 4'(tens_raw_s + 5'd6);
    end else begin
      tens_c_s = 1'b0;
      tens_s   = tens_raw_s[3:0];
    end
    result = {tens_c_s, tens_s, ones_s};
  end

endmodule

// File: rtl/exp_seq_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Metastability chain and previous-value register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/exp_seq_ctrl.sv
// Expansion-term sequencer: steps cur_exp 0..LAST_EXP on button or dwell timer
// and accumulates each term into a saturating 2-digit BCD running sum.
module exp_seq_ctrl
  import exp_seq_ctrl_pkg::*;
#(
  parameter int         DWELL_CYCLES = 50_000_000,
  parameter logic [3:0] LAST_EXP     = 4'h9
) (
  input  logic           clk,
  input  logic           rst,
  exp_seq_ctrl_if.slave  bus
);

  localparam int               CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_r;
  logic             run_r;
  logic [3:0]       cur_exp_r;
  logic [7:0]       sum_val_r;
  logic             load_r;
  logic             ovf_r;
  logic             done_r;
  logic [CNT_W-1:0] dwell_r;

  logic       start_pulse_s;
  logic       step_pulse_s;
  logic       advance_s;
  logic [8:0] add_s;

  btn_sync_edge u_start_sync (.clk(clk), .rst(rst), .btn(bus.start_btn), .pulse(start_pulse_s));
  btn_sync_edge u_step_sync  (.clk(clk), .rst(rst), .btn(bus.step_btn),  .pulse(step_pulse_s));

  bcd_add8 u_add (.a(sum_val_r), .b(bus.term_bcd), .result(add_s));

  assign advance_s = step_pulse_s || (bus.auto_en && (dwell_r == DWELL_LAST));

  // Sequencer FSM with all outputs registered; start always wins over step/timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      run_r     <= 1'b0;
      cur_exp_r <= BCD_0;
      sum_val_r <= {BCD_0, BCD_0};
      load_r    <= 1'b0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
      dwell_r   <= {CNT_W{1'b0}};
    end else begin
      load_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          run_r  <= 1'b0;
          done_r <= 1'b0;
          if (start_pulse_s) begin
            state_r   <= ST_ACCUM;
            cur_exp_r <= BCD_0;
            sum_val_r <= {BCD_0, BCD_0};
            ovf_r     <= 1'b0;
            run_r     <= 1'b1;
            load_r    <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (start_pulse_s) begin
            state_r <= ST_IDLE;
            run_r   <= 1'b0;
          end else begin
            // Saturation is sticky until the next fresh start
            if (ovf_r || add_s[8]) begin
              sum_val_r <= BCD_SAT;
              ovf_r     <= 1'b1;
            end else begin
              sum_val_r <= add_s[7:0];
            end
            dwell_r <= {CNT_W{1'b0}};
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (start_pulse_s) begin
            state_r <= ST_IDLE;
            run_r   <= 1'b0;
          end else if (advance_s) begin
            if (cur_exp_r == LAST_EXP) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              cur_exp_r <= bcd_inc(cur_exp_r);
              state_r   <= ST_ACCUM;
              load_r    <= 1'b1;
            end
          end else if (bus.auto_en) begin
            dwell_r <= dwell_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          run_r  <= 1'b1;
          done_r <= 1'b1;
          if (start_pulse_s) begin
            state_r <= ST_IDLE;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          run_r   <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run     = run_r;
  assign bus.cur_exp = cur_exp_r;
  assign bus.sum_val = sum_val_r;
  assign bus.load    = load_r;
  assign bus.ovf     = ovf_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// Self-checking bench for exp_seq_ctrl: scoreboard on every load pulse,
// a vector table for BCD carry/clamp/overflow, and hand-written corner sequences.
module tb_exp_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_seq_ctrl_if bus();

  exp_seq_ctrl #(.DWELL_CYCLES(4), .LAST_EXP(4'h9)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External term table addressed by the current index
  logic [7:0] term_tab [16];
  assign bus.term_bcd = term_tab[bus.cur_exp];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] sum;
    logic       ovf;
  } sb_t;
  sb_t sb_q[$];
  sb_t cur;
  bit  pend = 1'b0;

  typedef struct {
    bit         restart;
    logic [7:0] term;
    logic [7:0] exp_sum;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] m_sum;
  logic       m_ovf;
  int         m_idx;
  int         t_exp[10];
  int         t_done;
  logic [3:0] last_exp;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.run, bus.cur_exp, bus.sum_val, bus.load, bus.ovf, bus.done};
  endfunction

  // Decimal reference: clamp digits, add, saturate at 99. Returns {ovf, sum}.
  function automatic logic [8:0] ref_add(input logic [7:0] s, input logic [7:0] t);
    int a, b, r;
    a = int'(s[7:4]) * 10 + int'(s[3:0]);
    b = ((t[7:4] > 4'd9) ? 9 : int'(t[7:4])) * 10 + ((t[3:0] > 4'd9) ? 9 : int'(t[3:0]));
    r = a + b;
    if (r > 99) return {1'b1, 8'h99};
    return {1'b0, 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic model_accum();
    logic [8:0] r;
    r = ref_add(m_sum, term_tab[m_idx]);
    if (m_ovf || r[8]) begin
      m_sum = 8'h99;
      m_ovf = 1'b1;
    end else begin
      m_sum = r[7:0];
    end
    sb_q.push_back('{4'(m_idx), m_sum, m_ovf});
  endtask

  task automatic press(input bit do_start, input bit do_step);
    @(negedge clk);
    bus.start_btn = do_start;
    bus.step_btn  = do_step;
    @(negedge clk);
    bus.start_btn = 1'b0;
    bus.step_btn  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_start();
    m_idx = 0;
    m_sum = 8'h00;
    m_ovf = 1'b0;
    model_accum();
    press(1'b1, 1'b0);
  endtask

  task automatic run_step();
    m_idx++;
    model_accum();
    press(1'b0, 1'b1);
  endtask

  // Scoreboard: each load pops one expectation; sum/ovf checked the cycle after
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("sb_sum", bus.sum_val, cur.sum);
        check("sb_ovf", bus.ovf, cur.ovf);
        pend = 1'b0;
      end
      if (bus.load) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_load: load=1 required 0 at cur_exp %0h", bus.cur_exp);
        end else begin
          cur = sb_q.pop_front();
          check("sb_idx", bus.cur_exp, cur.idx);
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst = 1'b1;
    bus.start_btn = 1'b0;
    bus.step_btn  = 1'b0;
    bus.auto_en   = 1'b0;
    for (int i = 0; i < 16; i++) term_tab[i] = 8'h05;
    vecs[0] = '{1'b1, 8'h48, 8'h48, 1'b0};
    vecs[1] = '{1'b0, 8'h37, 8'h85, 1'b0};
    vecs[2] = '{1'b0, 8'h0C, 8'h94, 1'b0};
    vecs[3] = '{1'b1, 8'h60, 8'h60, 1'b0};
    vecs[4] = '{1'b0, 8'h60, 8'h99, 1'b1};
    vecs[5] = '{1'b0, 8'h01, 8'h99, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Manual run, constant term 0x05
    run_start();
    check("man_run", bus.run, 1'b1);
    check("man_first_sum", bus.sum_val, 8'h05);
    for (int i = 0; i < 9; i++) run_step();
    check("man_cur_exp9", bus.cur_exp, 4'h9);
    check("man_sum9", bus.sum_val, 8'h50);
    check("man_not_done", bus.done, 1'b0);
    press(1'b0, 1'b1);
    check("man_done", {bus.run, bus.done, bus.cur_exp, bus.sum_val}, {1'b1, 1'b1, 4'h9, 8'h50});
    press(1'b0, 1'b1);
    check("done_step_ignored", {bus.done, bus.cur_exp, bus.sum_val}, {1'b1, 4'h9, 8'h50});
    press(1'b1, 1'b0);
    check("done_start_idle", {bus.run, bus.done}, 2'b00);

    // Vector table: BCD carry, nibble clamp, saturation
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].restart) begin
        if (i != 0) begin
          press(1'b1, 1'b0);
          check("abort_run", bus.run, 1'b0);
          check("abort_hold_sum", bus.sum_val, vecs[i-1].exp_sum);
        end
        idx = 0;
      end else begin
        idx++;
      end
      term_tab[idx] = vecs[i].term;
      sb_q.push_back('{4'(idx), vecs[i].exp_sum, vecs[i].exp_ovf});
      press(vecs[i].restart, !vecs[i].restart);
      check($sformatf("vec%0d_sum", i), bus.sum_val, vecs[i].exp_sum);
      check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].exp_ovf);
    end

    // Asynchronous reset in WAIT with cur_exp=4, sum=0x20
    press(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) term_tab[i] = 8'h04;
    run_start();
    for (int i = 0; i < 4; i++) run_step();
    check("pre_reset_state", {bus.run, bus.cur_exp, bus.sum_val}, {1'b1, 4'h4, 8'h20});
    #2 rst = 1'b1;
    #1 check("async_reset", outs(), 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    press(1'b0, 1'b1);
    check("post_reset_step", outs(), 16'h0000);

    // Auto mode: period DWELL_CYCLES+1 = 5
    for (int i = 0; i < 16; i++) term_tab[i] = 8'h01;
    m_sum = 8'h00;
    m_ovf = 1'b0;
    for (int k = 0; k < 10; k++) begin
      m_idx = k;
      model_accum();
    end
    bus.auto_en = 1'b1;
    for (int k = 0; k < 10; k++) t_exp[k] = -1;
    t_done   = -1;
    last_exp = bus.cur_exp;
    @(negedge clk);
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b0;
    for (int c = 0; c < 200 && t_done < 0; c++) begin
      @(negedge clk);
      if (bus.cur_exp != last_exp) begin
        last_exp = bus.cur_exp;
        if (last_exp <= 4'h9) t_exp[last_exp] = c;
      end
      if (bus.done) t_done = c;
    end
    check("auto_done_seen", bus.done, 1'b1);
    for (int k = 2; k < 10; k++)
      check($sformatf("auto_period_%0d", k), 16'(t_exp[k] - t_exp[k-1]), 16'd5);
    check("auto_done_delay", 16'(t_done - t_exp[9]), 16'd5);
    check("auto_final", {bus.cur_exp, bus.sum_val, bus.ovf}, {4'h9, 8'h10, 1'b0});
    bus.auto_en = 1'b0;
    press(1'b1, 1'b0);
    check("auto_exit", {bus.run, bus.done}, 2'b00);

    // Simultaneous start and step in WAIT: abort wins, no accumulate
    for (int i = 0; i < 16; i++) term_tab[i] = 8'h03;
    run_start();
    run_step();
    check("simul_pre", bus.cur_exp, 4'h1);
    press(1'b1, 1'b1);
    check("simul_abort", {bus.run, bus.done, bus.cur_exp, bus.sum_val}, {1'b0, 1'b0, 4'h1, 8'h06});
    repeat (4) @(negedge clk);
    check("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
